tpiu_trace_capture: RTL and testbench
=====================================

// Module: tpiu_trace_capture
// PURPOSE
//  Consumes the 4-bit TRACEDATA stream (one nibble per clk, SDR) from the trace port
//  (real TPIU pins or the simulation trace generator), finds TPIU full-sync frame alignment,
//  packs nibbles into 32-bit words, discards sync words and buffers the rest in a FIFO
//  for the host-readout / register-interface stage downstream.
// PARAMETERS
//  FIFO_DEPTH  16          word FIFO entries; power of 2, >= 2
//  SYNC_WORD   32'h7FFFFFFF TPIU full-sync word, LSB nibble arrives first
// PORTS
//  clk         in   1   capture clock; TRACEDATA sampled on rising edge
//  reset       in   1   asynchronous, active-high reset
//  TRACEDATA   in   4   trace port nibble
//  capture_en  in   1   1 = capture; 0 = return to HUNT, FIFO contents kept
//  clear       in   1   sync pulse: empty FIFO, clear overflow and word_count
//  out_data    out  32  FIFO head word
//  out_valid   out  1   FIFO non-empty
//  out_ready   in   1   pop head when out_valid & out_ready
//  locked      out  1   1 while in LOCKED state
//  overflow    out  1   sticky: a word was dropped because the FIFO was full
//  word_count  out  16  words written to FIFO since reset/clear; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (async): state=HUNT, shift reg=0, nibble count=0, FIFO empty, out_valid=0,
//    out_data=0, locked=0, overflow=0, word_count=0.
//  - Shift reg: every enabled edge sr <= {TRACEDATA, sr[31:4]}; nxt = {TRACEDATA, sr[31:4]}.
//  - HUNT: if capture_en & nxt==SYNC_WORD -> LOCKED, nibble count=0, locked=1 after that edge.
//    Sync word is not written to the FIFO.
//  - LOCKED: nibble count increments each edge, wraps 7->0. On the edge with count==7:
//    if nxt==SYNC_WORD discard (re-alignment check passes); else register nxt, word_stb=1.
//  - word_stb pushes into FIFO on the next edge: word complete at edge N -> in FIFO at N+1,
//    out_valid high after N+1 if FIFO was empty. Latency last nibble -> out_valid = 2 clks.
//  - capture_en=0: state -> HUNT at next edge, nibble count=0, pending word_stb still pushed.
//  - FIFO: first-word-fall-through; out_data = head entry, valid whenever out_valid=1.
//    Full & push & no pop: word dropped, overflow<=1, word_count unchanged.
//    Full & push & pop same cycle: both take effect, no overflow.
//    Empty & pop: ignored. Pointers wrap modulo FIFO_DEPTH.
//  - word_count increments on each accepted push; holds at 16'hFFFF.
//  - clear: at that edge FIFO emptied, overflow=0, word_count=0; a push in the same cycle
//    is discarded; state/lock unaffected. clear has priority over push/pop.
//  - No loss-of-lock detection beyond capture_en; host re-hunts by toggling capture_en.
// TESTING
//  1 Reset mid-stream: assert reset with 3 words buffered -> out_valid=0, locked=0,
//    word_count=0 immediately (async), no outputs change until sync seen again.
//  2 Nibbles F,F,F,F,F,F,F,7 then 1,0,2,0,3,0,4,0 -> locked=1 after 8th nibble;
//    out_data=32'h04030201, out_valid=1 exactly 2 clks after the 16th nibble; word_count=1.
//  3 Locked, send sync word then 8,7,6,5,4,3,2,1 -> sync dropped, single word 32'h12345678.
//  4 out_ready=0, push 17 words (FIFO_DEPTH=16) -> overflow=1, word_count=16, first 16
//    words read back in order once out_ready=1; overflow stays 1 until clear.
//  5 FIFO full, push and pop in same cycle -> overflow stays 0, count of entries unchanged.
//  6 capture_en=0 mid-word (after 3 nibbles) -> locked=0, partial word never emitted;
//    re-enable, 0xAB-misaligned data without sync -> nothing captured until next sync.

Source files
------------

// File: rtl/tpiu_trace_capture.sv
// TPIU trace capture: aligns the 4-bit TRACEDATA stream on the full-sync word, packs nibbles
// into 32-bit words, drops sync words and queues the rest in a first-word-fall-through FIFO.
module tpiu_trace_capture #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] SYNC_WORD  = 32'h7FFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  TRACEDATA,
    input  logic        capture_en,
    input  logic        clear,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        locked,
    output logic        overflow,
    output logic [15:0] word_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [31:0]   sr_p0;
    logic [31:0]   nxt;
    logic [2:0]    nib_cnt;
    logic [31:0]   word_p1;
    logic          vld_p1;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fill;
    logic          full, pop, push_ok;

    assign nxt = {TRACEDATA, sr_p0[31:4]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (capture_en && nxt == SYNC_WORD) state_nxt = LOCKED;
            LOCKED:  if (!capture_en) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    // Stage p0 -> p1: nibble assembly; a word completes when the count wraps 7 -> 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_p0   <= '0;
            nib_cnt <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= capture_en && (state == LOCKED) && (nib_cnt == 3'd7) && (nxt != SYNC_WORD);
            if (capture_en) sr_p0 <= nxt;
            if (!capture_en || state == HUNT) nib_cnt <= '0;
            else                              nib_cnt <= nib_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture_en && nib_cnt == 3'd7) word_p1 <= nxt;
    end

    // Stage p1 -> FIFO: a pop frees a slot for a simultaneous push even when full
    assign full    = (fill == (AW + 1)'(FIFO_DEPTH));
    assign pop     = out_ready && out_valid;
    assign push_ok = vld_p1 && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (vld_p1 && !push_ok) overflow <= 1'b1;
            if (push_ok && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            case ({push_ok, pop})
                2'b10:   fill <= fill + (AW + 1)'(1);
                2'b01:   fill <= fill - (AW + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= word_p1;
    end

    assign out_valid = (fill != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_tpiu_trace_capture.sv
// Bench for tpiu_trace_capture: directed scenarios plus randomized traffic checked against
// a word-level reference model (lock tracking, pending word, FIFO as a queue).
module tb_tpiu_trace_capture;

    localparam int          DEPTH = 16;
    localparam logic [31:0] SYNC  = 32'h7FFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  TRACEDATA = '0;
    logic        capture_en = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        locked;
    logic        overflow;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          m_locked;
    int          m_phase;
    logic [31:0] m_win;
    bit          m_pend_vld;
    logic [31:0] m_pend_word;
    logic [31:0] m_q[$];
    bit          m_ovf;
    int          m_wc;

    tpiu_trace_capture #(.FIFO_DEPTH(DEPTH), .SYNC_WORD(SYNC)) dut (
        .clk(clk), .reset(reset), .TRACEDATA(TRACEDATA), .capture_en(capture_en),
        .clear(clear), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .locked(locked), .overflow(overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_locked = 0; m_phase = 0; m_win = '0; m_pend_vld = 0; m_pend_word = '0;
        m_q.delete(); m_ovf = 0; m_wc = 0;
    endtask

    task automatic model_edge(input logic [3:0] nib, input bit en, input bit clr, input bit rdy);
        logic [31:0] win_n;
        win_n = {nib, m_win[31:4]};
        if (clr) begin
            m_q.delete(); m_ovf = 0; m_wc = 0;
        end else begin
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (m_pend_vld) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(m_pend_word);
                    if (m_wc < 65535) m_wc++;
                end else m_ovf = 1;
            end
        end
        m_pend_vld  = en && m_locked && (m_phase == 7) && (win_n != SYNC);
        m_pend_word = win_n;
        if (!en) begin
            m_locked = 0; m_phase = 0;
        end else begin
            m_win = win_n;
            if (!m_locked) begin
                if (win_n == SYNC) begin m_locked = 1; m_phase = 0; end
            end else m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic step(input logic [3:0] nib, input bit en, input bit clr, input bit rdy);
        TRACEDATA = nib; capture_en = en; clear = clr; out_ready = rdy;
        model_edge(nib, en, clr, rdy);
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy);
        for (int i = 0; i < 8; i++) step(w[4*i +: 4], 1, 0, rdy);
    endtask

    task automatic send_sync(input bit rdy);
        send_word(SYNC, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(4'h0, 0, 0, rdy);
    endtask

    task automatic clean_start();
        step(4'h0, 0, 1, 1);
        idle(2, 1);
        step(4'h0, 0, 1, 1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == SYNC) w = 32'h0;
        return w;
    endfunction

    task automatic test_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL reset_wc: got %0d want 0", word_count); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_lock_first_word();
        clean_start();
        for (int i = 0; i < 7; i++) step(4'hF, 1, 0, 0);
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %0b want 0", locked); end
        step(4'h7, 1, 0, 0);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_sync: got %0b want 1", locked); end
        send_word(32'h04030201, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_word_lat1: got %0b want 0", out_valid); end
        step(4'h0, 1, 0, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL first_word_lat2: got %0b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'h04030201) begin n_bad++; $display("FAIL first_word_data: got %h want 04030201", out_data); end
        n_cmp++; if (word_count !== 16'd1) begin n_bad++; $display("FAIL first_word_wc: got %0d want 1", word_count); end
    endtask

    task automatic test_resync();
        clean_start();
        send_sync(0);
        send_sync(0);
        send_word(32'h12345678, 0);
        idle(2, 0);
        n_cmp++; if (word_count !== 16'd1) begin n_bad++; $display("FAIL resync_wc: got %0d want 1", word_count); end
        n_cmp++; if (out_data !== 32'h12345678) begin n_bad++; $display("FAIL resync_data: got %h want 12345678", out_data); end
        step(4'h0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL resync_single: got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] w[17];
        clean_start();
        send_sync(0);
        for (int i = 0; i < 17; i++) begin w[i] = rand_word(); send_word(w[i], 0); end
        idle(2, 0);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b want 1", overflow); end
        n_cmp++; if (word_count !== 16'd16) begin n_bad++; $display("FAIL ovf_wc: got %0d want 16", word_count); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_data !== w[i] || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL ovf_read%0d: got %h/%0b want %h/1", i, out_data, out_valid, w[i]);
            end
            step(4'h0, 0, 0, 1);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %0b want 0", out_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        step(4'h0, 0, 1, 0);
        n_cmp++; if (overflow !== 1'b0 || word_count !== 16'd0) begin
            n_bad++; $display("FAIL ovf_clear: got %0b/%0d want 0/0", overflow, word_count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w[17];
        clean_start();
        send_sync(0);
        for (int i = 0; i < 17; i++) begin w[i] = rand_word(); send_word(w[i], 0); end
        step(4'h0, 0, 0, 1);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf: got %0b want 0", overflow); end
        n_cmp++; if (word_count !== 16'd17) begin n_bad++; $display("FAIL fpp_wc: got %0d want 17", word_count); end
        for (int i = 1; i < 17; i++) begin
            n_cmp++;
            if (out_data !== w[i] || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL fpp_read%0d: got %h/%0b want %h/1", i, out_data, out_valid, w[i]);
            end
            step(4'h0, 0, 0, 1);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_entries: got %0b want 0", out_valid); end
    endtask

    task automatic test_disable_midword();
        clean_start();
        send_sync(0);
        step(4'h1, 1, 0, 0); step(4'h2, 1, 0, 0); step(4'h3, 1, 0, 0);
        step(4'h0, 0, 0, 0);
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL dis_locked: got %0b want 0", locked); end
        idle(3, 0);
        n_cmp++; if (word_count !== 16'd0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL dis_partial: got %0d/%0b want 0/0", word_count, out_valid);
        end
        for (int i = 0; i < 32; i++) begin
            step((i % 2 == 0) ? 4'hA : 4'hB, 1, 0, 0);
            n_cmp++; if (locked !== 1'b0 || word_count !== 16'd0) begin
                n_bad++; $display("FAIL dis_misaligned%0d: got %0b/%0d want 0/0", i, locked, word_count);
            end
        end
        send_sync(0);
        send_word(32'hCAFE0123, 0);
        idle(2, 0);
        n_cmp++; if (out_data !== 32'hCAFE0123 || word_count !== 16'd1) begin
            n_bad++; $display("FAIL dis_relock: got %h/%0d want cafe0123/1", out_data, word_count);
        end
    endtask

    task automatic test_reset_midstream();
        clean_start();
        send_sync(0);
        for (int i = 0; i < 3; i++) send_word(rand_word(), 0);
        send_sync(0);
        n_cmp++; if (word_count !== 16'd3 || locked !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre: got %0d/%0b want 3/1", word_count, locked);
        end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || locked !== 1'b0 || word_count !== 16'd0 || out_data !== 32'h0) begin
            n_bad++; $display("FAIL rst_async: got %0b/%0b/%0d/%h want 0/0/0/0", out_valid, locked, word_count, out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            step((i % 2 == 0) ? 4'hA : 4'hB, 1, 0, 1);
            n_cmp++; if (out_valid !== 1'b0 || locked !== 1'b0) begin
                n_bad++; $display("FAIL rst_quiet%0d: got %0b/%0b want 0/0", i, out_valid, locked);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  nibq[$];
        logic [31:0] w;
        logic [31:0] exp_data;
        bit en, clr, rdy;
        clean_start();
        for (int c = 0; c < 1500; c++) begin
            if (nibq.size() == 0) begin
                w = ($urandom_range(0, 3) == 0) ? SYNC : $urandom;
                for (int i = 0; i < 8; i++) nibq.push_back(w[4*i +: 4]);
            end
            en  = ($urandom_range(0, 39) != 0);
            clr = ($urandom_range(0, 199) == 0);
            rdy = ((c / 150) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
            step(nibq.pop_front(), en, clr, rdy);
            exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
            n_cmp++;
            if (out_valid !== (m_q.size() > 0) || out_data !== exp_data || locked !== m_locked ||
                overflow !== m_ovf || word_count !== 16'(m_wc)) begin
                n_bad++;
                $display("FAIL rand_c%0d: got v=%0b d=%h l=%0b o=%0b wc=%0d want v=%0b d=%h l=%0b o=%0b wc=%0d",
                         c, out_valid, out_data, locked, overflow, word_count,
                         m_q.size() > 0, exp_data, m_locked, m_ovf, m_wc);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_first_word();
        test_resync();
        test_overflow();
        test_full_push_pop();
        test_disable_midword();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
